// File: rtl/piso_rr_scheduler.sv
// piso_rr_scheduler: shares one parallel-in/serial-out path between R word
// producers. A round-robin arbiter picks a requester while idle, loads its
// N-bit word and shifts it out MSB first with per-bit valid/last framing.
// Optional macro PISO_SCHED_PARITY_EN appends an even-parity bit to each frame.
module piso_rr_scheduler #(
    parameter int unsigned N = 4,
    parameter int unsigned R = 3
) (
    input  logic                 clk,
    input  logic                 reset_al_in,
    input  logic [R-1:0]         req_in,
    input  logic [R*N-1:0]       d_in,
    input  logic                 stall_in,
    output logic [R-1:0]         grant_out,
    output logic [$clog2(R)-1:0] src_out,
    output logic                 busy_out,
    output logic                 q_out,
    output logic                 q_valid_out,
    output logic                 q_last_out
);

`ifdef PISO_SCHED_PARITY_EN
    localparam int unsigned FL = N + 1;
`else
    localparam int unsigned FL = N;
`endif
    localparam int unsigned CW = $clog2(N + 2);
    localparam int unsigned SW = $clog2(R);
    localparam logic [CW-1:0] LAST_IDX = CW'(FL - 1);
    localparam logic [SW-1:0] MAX_IDX  = SW'(R - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [FL-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;     // index of the frame bit currently presented
    logic [SW-1:0] ptr_q, ptr_d;     // requester with highest priority next
    logic [R-1:0]  grant_q, grant_d;
    logic [SW-1:0] src_q, src_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;

    logic [N-1:0]  words [R];
    logic          sel_found;
    logic [SW-1:0] sel_idx;
    logic [SW-1:0] cand;
    logic [N-1:0]  sel_word;
    logic [FL-1:0] load_val;

    for (genvar g = 0; g < R; g++) begin : g_word
        assign words[g] = d_in[g*N +: N];
    end

    // Round-robin pick: first requesting index at or after ptr_q, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = ptr_q;
        for (int unsigned k = 0; k < R; k++) begin
            if (!sel_found && req_in[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
            cand = (cand == MAX_IDX) ? '0 : cand + 1'b1;
        end
    end

    assign sel_word = words[sel_idx];

`ifdef PISO_SCHED_PARITY_EN
    assign load_val = {sel_word, ^sel_word};
`else
    assign load_val = sel_word;
`endif

    // Next-state and registered-output logic for the IDLE/SHIFT controller.
    // The bit on q_out is taken by the link in its valid cycle; a stall only
    // delays presenting the following bit, so no bit is repeated or skipped.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        busy_d  = busy_q;
        grant_d = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d          = SHIFT;
                    shreg_d          = load_val;
                    cnt_d            = '0;
                    grant_d[sel_idx] = 1'b1;
                    src_d            = sel_idx;
                    ptr_d            = (sel_idx == MAX_IDX) ? '0 : sel_idx + 1'b1;
                    busy_d           = 1'b1;
                    valid_d          = 1'b1;
                end
            end
            SHIFT: begin
                if (stall_in) begin
                    valid_d = 1'b0;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    shreg_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q + 1'b1;
                    valid_d = 1'b1;
                    last_d  = ((cnt_q + 1'b1) == LAST_IDX);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            src_q   <= '0;
            busy_q  <= 1'b0;
            grant_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign grant_out   = grant_q;
    assign src_out     = src_q;
    assign busy_out    = busy_q;
    assign q_out       = shreg_q[FL-1];
    assign q_valid_out = valid_q;
    assign q_last_out  = last_q;

endmodule
